cpu_loader: RTL

- Parametrised successor to the CPU start sequencer.
- Holds the RISC-V path-planning CPU in reset and writes NUM_WORDS argument words into its data memory over the external write port. Arguments include the start node, end point and spare/mode words.
- After loading, releases the CPU and monitors it for completion or timeout.
- Sits between the bot's navigation controller and the CPU/memory wrapper; supports re-launch, abort and status reporting that the fixed 4-word starter lacks.

---
 rtl/cpu_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_loader.sv
// cpu_loader: launches the path-planning CPU by holding it in reset, writing
// NUM_WORDS argument words into its data memory, then releasing it. It then
// watches the CPU for completion, optional timeout or an abort request.
// All outputs are registered and are decoded from the next state, so the
// outputs seen in a cycle always describe the state held in that cycle.
module cpu_loader #(
   parameter int          NUM_WORDS  = 4,
   parameter int          ARG_W      = 5,
   parameter logic [31:0] BASE_ADR   = 32'h02000000,
   parameter int          ADR_STRIDE = 4,
   parameter int          GAP_CYCLES = 1,
   parameter int          TIMEOUT    = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [NUM_WORDS*ARG_W-1:0] args,
   input  logic                       cpu_done,
   output logic                       reset,
   output logic                       Ext_MemWrite,
   output logic [31:0]                Ext_WriteData,
   output logic [31:0]                Ext_DataAdr,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int SLOTS = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [3:0]       GAP_L    = 4'(GAP_CYCLES);
   localparam logic [31:0]      STRIDE_L = 32'(ADR_STRIDE);
   // RUN starts with the counter at 0; the pulse is registered one cycle after
   // the match, so matching at TIMEOUT-2 puts the pulse TIMEOUT cycles after
   // the release cycle.
   localparam logic [31:0]      TO_LIM   = (TIMEOUT >= 2) ? 32'(TIMEOUT - 2) : 32'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        phase_q, phase_d;     // 0 = write beat, 1..GAP = idle gap
   logic [31:0]       cnt_q, cnt_d;
   logic              reset_q, reset_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       adr_q, adr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;

   // Argument words zero-extended to the bus width; unused slots read as zero
   // so any index value selects a defined word.
   logic [31:0] word_ext [SLOTS];

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_words
         if (gi < NUM_WORDS) begin : g_used
            assign word_ext[gi] = 32'(args[gi*ARG_W +: ARG_W]);
         end else begin : g_pad
            assign word_ext[gi] = 32'd0;
         end
      end
   endgenerate

   // State register and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         phase_q   <= '0;
         cnt_q     <= '0;
         reset_q   <= 1'b1;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         adr_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         reset_q   <= reset_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         adr_q     <= adr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state sequencing, then output decode from the next state.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      reset_d   = reset_q;
      we_d      = 1'b0;
      wdata_d   = '0;
      adr_d     = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               idx_d   = '0;
               phase_d = '0;
            end
         end
         S_LOAD: begin
            // start and cpu_done are deliberately ignored while loading
            if (phase_q == GAP_L) begin
               phase_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_RELEASE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end
         S_RELEASE: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
         S_RUN: begin
            cnt_d = cnt_q + 32'd1;
            // completion beats timeout, timeout beats an abort request
            if (cpu_done) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LIM)) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else if (start) begin
               state_d = S_LOAD;
               idx_d   = '0;
               phase_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_LOAD: begin
            reset_d = 1'b1;
            busy_d  = 1'b1;
            if (phase_d == 4'd0) begin
               we_d    = 1'b1;
               wdata_d = word_ext[idx_d];
               adr_d   = BASE_ADR + 32'(idx_d) * STRIDE_L;
            end
         end
         S_RELEASE, S_RUN: begin
            reset_d = 1'b0;
            busy_d  = 1'b1;
         end
         default: begin
            // IDLE keeps the CPU running after completion, but a timeout
            // puts it back into reset.
            if (timeout_d) begin
               reset_d = 1'b1;
            end
         end
      endcase
   end

   assign reset         = reset_q;
   assign Ext_MemWrite  = we_q;
   assign Ext_WriteData = wdata_q;
   assign Ext_DataAdr   = adr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign timeout       = timeout_q;

endmodule
